// File: rtl/bw_io_hstl_drv_bank.sv
// HSTL driver bank front-end: registered pad controls, POR hold, crowbar block and quiet-window calibration update.
// Define HSTL_CAL_THERM_CHK_EN to reject non-thermometer calibration codes.
module bw_io_hstl_drv_bank #(
  parameter int NCH = 8,
  parameter int CW = 8,
  parameter int POR_HOLD = 4,
  parameter int IDLE_MIN = 2,
  parameter logic [CW-1:0] RST_CODE = CW'(8'h0F)
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           por,
  input  logic           sel_data_n,
  input  logic [NCH-1:0] pad_up,
  input  logic [NCH-1:0] pad_dn_l,
  input  logic [NCH-1:0] bsr_up,
  input  logic [NCH-1:0] bsr_dn_l,
  input  logic [CW-1:0]  cal_cbu,
  input  logic [CW-1:0]  cal_cbd,
  input  logic           cal_upd_req,
  output logic           cal_upd_ack,
  output logic [NCH-1:0] drv_up,
  output logic [NCH-1:0] drv_dn_l,
  output logic [CW-1:0]  cbu,
  output logic [CW-1:0]  cbd,
  output logic           drv_rdy,
  output logic [NCH-1:0] illegal_err,
  output logic           cal_err
);

  localparam int HW = $clog2(POR_HOLD + 1);
  localparam int IW = $clog2(IDLE_MIN + 1);

  typedef enum logic [1:0] {
    HOLD,
    ACTIVE,
    CAL_WAIT,
    CAL_APPLY
  } state_t;

  state_t         state;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_nxt;
  logic [IW-1:0]  idle_cnt;
  logic [IW-1:0]  idle_nxt;
  logic [NCH-1:0] up_sel;
  logic [NCH-1:0] dn_sel;
  logic [NCH-1:0] up_leg;
  logic [NCH-1:0] dn_leg;
  logic [NCH-1:0] xbar;
  logic           quiet;

  assign up_sel = sel_data_n ? bsr_up : pad_up;
  assign dn_sel = sel_data_n ? bsr_dn_l : pad_dn_l;
  assign xbar = up_sel & ~dn_sel;
  // Crowbar {1,0} collapses to hi-Z {0,1}; legal codes pass through.
  assign up_leg = up_sel & dn_sel;
  assign dn_leg = dn_sel | up_sel;
  assign quiet = &(~up_sel & dn_sel);
  assign hold_nxt = hold_cnt + 1'b1;
  assign idle_nxt = idle_cnt + 1'b1;

`ifdef HSTL_CAL_THERM_CHK_EN
  function automatic logic therm(input logic [CW-1:0] c);
    return (c & CW'(c + 1'b1)) == '0;
  endfunction

  logic code_ok;
  logic cal_err_q;

  assign code_ok = therm(cal_cbu) & therm(cal_cbd);
  assign cal_err = cal_err_q;
`else
  assign cal_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= HOLD;
      hold_cnt <= '0;
      idle_cnt <= '0;
      drv_up <= '0;
      drv_dn_l <= '1;
      cbu <= RST_CODE;
      cbd <= RST_CODE;
      drv_rdy <= 1'b0;
      cal_upd_ack <= 1'b0;
      illegal_err <= '0;
`ifdef HSTL_CAL_THERM_CHK_EN
      cal_err_q <= 1'b0;
`endif
    end else begin
      illegal_err <= illegal_err | xbar;
      cal_upd_ack <= 1'b0;
`ifdef HSTL_CAL_THERM_CHK_EN
      cal_err_q <= 1'b0;
`endif
      if (por) begin
        state <= HOLD;
        hold_cnt <= '0;
        drv_up <= '0;
        drv_dn_l <= '1;
        drv_rdy <= 1'b0;
      end else begin
        unique case (state)
          HOLD: begin
            drv_up <= '0;
            drv_dn_l <= '1;
            hold_cnt <= hold_nxt;
            if (hold_nxt == HW'(POR_HOLD)) begin
              state <= ACTIVE;
              drv_rdy <= 1'b1;
            end
          end
          ACTIVE: begin
            drv_up <= up_leg;
            drv_dn_l <= dn_leg;
            // The ack cycle is the first ACTIVE cycle; req is still high there.
            if (cal_upd_req && !cal_upd_ack) begin
              state <= CAL_WAIT;
              idle_cnt <= '0;
            end
          end
          CAL_WAIT: begin
            drv_up <= up_leg;
            drv_dn_l <= dn_leg;
            if (!cal_upd_req) begin
              state <= ACTIVE;
            end else if (!quiet) begin
              idle_cnt <= '0;
            end else if (idle_nxt == IW'(IDLE_MIN)) begin
              state <= CAL_APPLY;
            end else begin
              idle_cnt <= idle_nxt;
            end
          end
          CAL_APPLY: begin
            drv_up <= '0;
            drv_dn_l <= '1;
            cal_upd_ack <= 1'b1;
            state <= ACTIVE;
`ifdef HSTL_CAL_THERM_CHK_EN
            if (code_ok) begin
              cbu <= cal_cbu;
              cbd <= cal_cbd;
            end else begin
              cal_err_q <= 1'b1;
            end
`else
            cbu <= cal_cbu;
            cbd <= cal_cbd;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bw_io_hstl_drv_bank.sv
// Directed table-driven bench for bw_io_hstl_drv_bank.
// Covers POR hold, path select, crowbar flag, calibration handshake and POR abort.
module tb_bw_io_hstl_drv_bank;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       por;
  logic       sel_data_n;
  logic [7:0] pad_up;
  logic [7:0] pad_dn_l;
  logic [7:0] bsr_up;
  logic [7:0] bsr_dn_l;
  logic [7:0] cal_cbu;
  logic [7:0] cal_cbd;
  logic       cal_upd_req;
  logic       cal_upd_ack;
  logic [7:0] drv_up;
  logic [7:0] drv_dn_l;
  logic [7:0] cbu;
  logic [7:0] cbd;
  logic       drv_rdy;
  logic [7:0] illegal_err;
  logic       cal_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bw_io_hstl_drv_bank dut (
    .clk(clk),
    .rst_l(rst_l),
    .por(por),
    .sel_data_n(sel_data_n),
    .pad_up(pad_up),
    .pad_dn_l(pad_dn_l),
    .bsr_up(bsr_up),
    .bsr_dn_l(bsr_dn_l),
    .cal_cbu(cal_cbu),
    .cal_cbd(cal_cbd),
    .cal_upd_req(cal_upd_req),
    .cal_upd_ack(cal_upd_ack),
    .drv_up(drv_up),
    .drv_dn_l(drv_dn_l),
    .cbu(cbu),
    .cbd(cbd),
    .drv_rdy(drv_rdy),
    .illegal_err(illegal_err),
    .cal_err(cal_err)
  );

  typedef struct {
    logic       sel;
    logic [7:0] pu;
    logic [7:0] pd;
    logic [7:0] bu;
    logic [7:0] bd;
    logic [7:0] e_up;
    logic [7:0] e_dn;
    logic [7:0] e_ill;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_hiz();
    sel_data_n = 1'b0;
    pad_up = 8'h00;
    pad_dn_l = 8'hFF;
    bsr_up = 8'h00;
    bsr_dn_l = 8'hFF;
  endtask

  task automatic wait_rdy(input string name, input int want);
    int n;
    n = 0;
    while (!drv_rdy && n < 20) begin
      step();
      n++;
      chk({name, "_up"}, drv_up, 8'h00);
      chk({name, "_dn"}, drv_dn_l, 8'hFF);
    end
    chk({name, "_cycles"}, n, want);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 8'hF0, 8'hF0, 8'h00, 8'hFF, 8'hF0, 8'hF0, 8'h00};
    vecs[1] = '{1'b1, 8'hF0, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{1'b0, 8'h08, 8'hF7, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h08};
    vecs[3] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h08};
    vecs[4] = '{1'b0, 8'h81, 8'h81, 8'h00, 8'hFF, 8'h81, 8'h81, 8'h08};
    vecs[5] = '{1'b1, 8'h81, 8'h81, 8'h01, 8'hFE, 8'h00, 8'hFF, 8'h09};
    vecs[6] = '{1'b1, 8'h81, 8'h81, 8'h02, 8'hFF, 8'h02, 8'hFF, 8'h09};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h09};

    rst_l = 1'b0;
    por = 1'b1;
    all_hiz();
    cal_cbu = 8'h00;
    cal_cbd = 8'h00;
    cal_upd_req = 1'b0;
    #12;
    chk("rst_up", drv_up, 8'h00);
    chk("rst_dn", drv_dn_l, 8'hFF);
    chk("rst_cbu", cbu, 8'h0F);
    chk("rst_cbd", cbd, 8'h0F);
    chk("rst_rdy", drv_rdy, 0);
    chk("rst_ack", cal_upd_ack, 0);
    chk("rst_ill", illegal_err, 8'h00);
    chk("rst_err", cal_err, 0);

    step();
    rst_l = 1'b1;
    pad_up = 8'hFF;
    pad_dn_l = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("por_up", drv_up, 8'h00);
      chk("por_rdy", drv_rdy, 0);
    end
    por = 1'b0;
    wait_rdy("hold", 4);
    chk("hold_cbu", cbu, 8'h0F);
    chk("hold_cbd", cbd, 8'h0F);

    for (int i = 0; i < 8; i++) begin
      sel_data_n = vecs[i].sel;
      pad_up = vecs[i].pu;
      pad_dn_l = vecs[i].pd;
      bsr_up = vecs[i].bu;
      bsr_dn_l = vecs[i].bd;
      step();
      chk($sformatf("vec%0d_up", i), drv_up, vecs[i].e_up);
      chk($sformatf("vec%0d_dn", i), drv_dn_l, vecs[i].e_dn);
      chk($sformatf("vec%0d_ill", i), illegal_err, vecs[i].e_ill);
    end

    // Calibration request while channel 0 drives 1
    all_hiz();
    pad_up = 8'h01;
    cal_cbu = 8'h3F;
    cal_cbd = 8'h1F;
    cal_upd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_ack", cal_upd_ack, 0);
      chk("busy_cbu", cbu, 8'h0F);
    end
    pad_up = 8'h00;
    n = 0;
    while (!cal_upd_ack && n < 10) begin
      step();
      n++;
    end
    // Two quiet samples, then the one-cycle apply state.
    chk("cal_lat", n, 3);
    chk("cal_cbu", cbu, 8'h3F);
    chk("cal_cbd", cbd, 8'h1F);
    chk("cal_dn", drv_dn_l, 8'hFF);
    chk("cal_rdy", drv_rdy, 1);
    cal_upd_req = 1'b0;
    step();
    chk("ack_pulse", cal_upd_ack, 0);
    chk("post_cbu", cbu, 8'h3F);

    // POR on the apply cycle aborts the update
    cal_cbu = 8'h07;
    cal_cbd = 8'h03;
    cal_upd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_ack", cal_upd_ack, 0);
    end
    por = 1'b1;
    step();
    chk("ab_ack2", cal_upd_ack, 0);
    chk("ab_cbu", cbu, 8'h3F);
    chk("ab_cbd", cbd, 8'h1F);
    chk("ab_rdy", drv_rdy, 0);
    cal_upd_req = 1'b0;
    por = 1'b0;
    wait_rdy("rehold", 4);

    // Non-thermometer code
    cal_cbu = 8'h05;
    cal_cbd = 8'h03;
    cal_upd_req = 1'b1;
    n = 0;
    while (!cal_upd_ack && n < 10) begin
      step();
      n++;
    end
    chk("th_lat", n, 4);
    chk("th_ack", cal_upd_ack, 1);
`ifdef HSTL_CAL_THERM_CHK_EN
    chk("th_err", cal_err, 1);
    chk("th_cbu", cbu, 8'h3F);
    chk("th_cbd", cbd, 8'h1F);
`else
    chk("th_err", cal_err, 0);
    chk("th_cbu", cbu, 8'h05);
    chk("th_cbd", cbd, 8'h03);
`endif
    cal_upd_req = 1'b0;
    step();
    chk("th_err_clr", cal_err, 0);

    rst_l = 1'b0;
    #2;
    chk("rst2_ill", illegal_err, 8'h00);
    chk("rst2_cbu", cbu, 8'h0F);
    chk("rst2_rdy", drv_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
